// File: rtl/branch_resolve_queue.sv
// ---------------------------------------------------------------------------
// branch_resolve_queue : in-order predicted-branch queue feeding GShare training
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module branch_resolve_queue #(
  parameter int DEPTH = 8,
  parameter int PC_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [PC_W-1:0]          pushPc,
  input  logic                     pushPred,
  input  logic                     resolve,
  input  logic                     taken,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [PC_W-1:0]          updatePc,
  output logic                     update,
  output logic                     reality,
  output logic                     mispredict,
  output logic                     overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PC_W-1:0]  pc_mem [DEPTH];
  logic [DEPTH-1:0] pred_mem;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;

  logic             do_resolve;
  logic             do_mis;
  logic             do_push;
  logic             drop_full;
  logic [CNT_W-1:0] count_nxt;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // A full queue still accepts a push when a correct resolve frees a slot;
  // a mispredict discards any same-cycle push as wrong-path.
  assign do_resolve = resolve && !empty;
  assign do_mis     = do_resolve && (taken != pred_mem[head]);
  assign do_push    = push && !do_mis && (!full || do_resolve);
  assign drop_full  = push && full && !do_resolve;

  always_comb begin
    count_nxt = count;
    if (do_mis) begin
      count_nxt = '0;
    end else if (do_push && !do_resolve) begin
      count_nxt = count + CNT_W'(1);
    end else if (!do_push && do_resolve) begin
      count_nxt = count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      update     <= 1'b0;
      reality    <= 1'b0;
      mispredict <= 1'b0;
      overflow   <= 1'b0;
      updatePc   <= '0;
    end else begin
      count      <= count_nxt;
      update     <= do_resolve;
      reality    <= do_resolve && taken;
      mispredict <= do_mis;
      if (drop_full) begin
        overflow <= 1'b1;
      end
      if (do_resolve) begin
        updatePc <= pc_mem[head];
        head     <= head + PTR_W'(1);
      end
      // Flush leaves the queue empty just past the popped slot.
      if (do_mis) begin
        tail <= head + PTR_W'(1);
      end else if (do_push) begin
        tail <= tail + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      pc_mem[tail]   <= pushPc;
      pred_mem[tail] <= pushPred;
    end
  end

endmodule

`default_nettype wire

// File: doc/branch_resolve_queue.md
# branch_resolve_queue

In-order queue between fetch and execute that holds every branch the GShare predictor has predicted until execute resolves it. At resolution it compares the actual outcome with the stored prediction and drives the GShare training port (updatePc, update, reality) one cycle later. On a misprediction it raises a flush pulse and discards all younger, wrong-path entries.

## Interface
- DEPTH, 8, number of in-flight branch entries; power of two, at least 2
- PC_W, 32, branch PC width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- push  in  1  fetch issued a predicted branch this cycle
- pushPc  in  PC_W  PC of that branch (the value presented to GShare as predictPc)
- pushPred  in  1  GShare prediction for that branch; 1 = taken
- resolve  in  1  execute resolved the oldest outstanding branch this cycle
- taken  in  1  actual outcome of the resolved branch
- full  out  1  combinational, count == DEPTH
- empty  out  1  combinational, count == 0
- count  out  $clog2(DEPTH)+1  registered occupancy
- updatePc  out  PC_W  registered PC to train; connects to GShare updatePc
- update  out  1  registered one-cycle training strobe; connects to GShare update
- reality  out  1  registered actual outcome; connects to GShare reality
- mispredict  out  1  registered one-cycle flush pulse to fetch
- overflow  out  1  sticky; set when a push is dropped because the queue is full, cleared only by reset

## Operation
- Storage: DEPTH entries of {pc, pred}. Head and tail pointers are log2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0. The count register tracks occupancy.
- Accepted resolve: resolve=1 and empty=0.
  - The head entry is popped.
  - Next edge: update=1, updatePc=head.pc, reality=taken, mispredict=(taken != head.pred).
- Ignored resolve: resolve=1 with empty=1 is ignored. No strobe is produced, state is unchanged, and no error is flagged.
- Accepted push: push=1 and either full=0, or full=1 while an accepted, correctly predicted resolve occurs in the same cycle. The entry is written at tail and tail advances.
- Dropped push: push=1 with full=1 and no freeing resolve. The entry is dropped and overflow is set.
- Correct resolve plus accepted push in the same cycle: count is unchanged and both pointers advance.
- Mispredicting resolve (accepted resolve with taken != head.pred):
  - At that edge the queue empties: count=0 and tail=head+1 (the popped slot).
  - Any push in the same cycle is dropped as wrong-path. overflow is not set by this drop.
- Cycles without an accepted resolve: update, reality and mispredict are 0. updatePc holds its last value.
- Reset (rst_n low, async):
  - head=tail=0, count=0, so empty=1 and full=0.
  - update=0, reality=0, mispredict=0, overflow=0, updatePc=0.
  - Entry contents are don't-care.
  - Asserting reset mid-operation discards all entries and any pending strobe immediately.

## Timing
- Push in cycle N: visible in count/empty/full after edge N. The earliest resolve of that entry is cycle N+1. There is no push-to-resolve bypass.
- Resolve in cycle N produces update/reality/updatePc/mispredict in cycle N+1, valid for exactly one cycle.
- Back-to-back resolves produce back-to-back update pulses, one per cycle, in program order.
- The cycle after a mispredict, the queue is empty. A push in that cycle (correct-path refetch) is accepted normally.
- full/empty are combinational from the count register only, never from same-cycle inputs.

## Test plan
- Reset then idle: rst_n low for 2 cycles, release → count=0, empty=1, full=0, update=0, mispredict=0, overflow=0.
- Correct prediction: push pushPc=0x1, pushPred=0; next cycle resolve with taken=0 → one cycle later update=1, updatePc=0x1, reality=0, mispredict=0; count returns to 0.
- Mispredict flush: push PCs 0x1(pred 0), 0x2, 0x3; resolve with taken=1 → next cycle update=1, updatePc=0x1, reality=1, mispredict=1, count=0; a push presented during the resolve cycle is not stored.
- Full/wrap/overflow (DEPTH=8): push 8 branches → full=1; a 9th push alone → dropped, overflow=1; then over 20 cycles push and resolve together with matching outcomes → count stays 8, updatePc sequence is in order, pointers wrap past 7 with no corruption.
- Empty resolve and async reset: resolve with empty=1 → no update pulse. With 3 entries queued and a resolve in flight, pull rst_n low mid-cycle → count=0, update=0 immediately, without waiting for a clock edge.
